// File: rtl/mul_sequencer_pkg.sv
// Shared types for the sequential multiplier: operand width, op codes,
// FSM states and the iteration-count type.
package mul_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULH  = 2'b01,
    MULHU = 2'b10
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [4:0] iter_t;

  // The unused encoding 2'b11 behaves as a plain low-word multiply.
  function automatic op_t decode_op(input logic [1:0] raw);
    case (raw)
      2'b01:   return MULH;
      2'b10:   return MULHU;
      default: return MUL;
    endcase
  endfunction

endpackage

// File: rtl/mul_sequencer_dp.sv
// Shift-add datapath for mul_sequencer: magnitude preparation, 64-bit
// accumulator and final sign fix. MUL_SEQUENCER_EARLY_EXIT_EN enables early finish.
module mul_sequencer_dp
  import mul_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  op_t               op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  iter_t             cnt,
  output logic              last,
  output logic [2*XLEN-1:0] product
);

  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              neg;

  always_comb begin
    mag_a    = (op == MULH && a[XLEN-1]) ? -a : a;
    mag_b    = (op == MULH && b[XLEN-1]) ? -b : b;
    acc_next = acc + (mplier[0] ? mcand : '0);
    // Sign fix applied to the accumulator including the current iteration,
    // so the value is ready on the edge that enters DONE.
    product  = neg ? -acc_next : acc_next;
  end

`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
  assign last = (cnt == 5'd31) || (mplier == '0);
`else
  assign last = (cnt == 5'd31);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= {{XLEN{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      neg    <= (op == MULH) && (a[XLEN-1] ^ b[XLEN-1]);
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiplier sequencer: IDLE/RUN/DONE FSM, iteration counter and
// pipeline handshake. MUL_SEQUENCER_EARLY_EXIT_EN (in the datapath) allows early finish.
module mul_sequencer
  import mul_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t            state;
  iter_t             cnt;
  op_t               op_q;
  op_t               op_in;
  logic              accept;
  logic              last;
  logic [2*XLEN-1:0] product;

  assign op_in  = decode_op(op);
  assign accept = (state != RUN) && start && !flush;
  assign stall  = !rst && (busy || accept);

  mul_sequencer_dp u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (state == RUN),
    .op      (op_in),
    .a       (a),
    .b       (b),
    .cnt     (cnt),
    .last    (last),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= MUL;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= (op_q == MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            op_q  <= op_in;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: stimulus pushes expected completions,
// a negedge monitor checks busy/stall/done/result every cycle.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        stall, busy, done;
  logic [31:0] result;

  mul_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    int          acc_cyc;
    int          done_cyc;
    logic [31:0] res;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint          sx, sy, sp;
    longint unsigned up;
    sx = $signed(x);
    sy = $signed(y);
    sp = sx * sy;
    up = {32'b0, x} * {32'b0, y};
    case (o)
      2'b01:   return sp[63:32];
      2'b10:   return up[63:32];
      default: return up[31:0];
    endcase
  endfunction

  // Number of RUN cycles: 32 normally; with early exit, one per significant
  // multiplier bit plus the cycle that sees the remainder as zero.
  function automatic int exp_runs(input logic [1:0] o, input logic [31:0] y);
    logic [31:0] m;
    int          bl;
    m  = (o == 2'b01 && y[31]) ? -y : y;
    bl = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
    if (!EARLY) return 32;
    return (bl + 1 > 32) ? 32 : bl + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_busy;
      exp_t e;
      exp_busy = q.size() > 0 && cyc > q[0].acc_cyc && cyc < q[0].done_cyc;
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      check("stall", {31'b0, stall},
            {31'b0, !rst && (exp_busy || (start && !flush && !exp_busy))});
      if (done) begin
        if (q.size() > 0 && q[0].done_cyc == cyc) begin
          e = q.pop_front();
          check("result", result, e.res);
          last_res = e.res;
        end else begin
          check("done_spurious", {31'b0, done}, 32'd0);
        end
      end else if (q.size() > 0 && q[0].done_cyc <= cyc) begin
        check("done_missing", {31'b0, done}, 32'd1);
        void'(q.pop_front());
      end else begin
        check("result_hold", result, last_res);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    e.acc_cyc  = cyc;
    e.done_cyc = cyc + 1 + exp_runs(o, y);
    e.res      = model_res(o, x, y);
    q.push_back(e);
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL timeout: got busy expected idle at cycle %0d", cyc);
      q.delete();
    end
    tick();
  endtask

  task automatic flush_now();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
  endtask

  task automatic back_to_back(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int d;
    d = q[0].done_cyc - cyc;
    repeat (d) tick();
    start_op(o, x, y);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    start = 1'b1;
    tick();
    start  = 1'b0;
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    start_op(2'b00, 32'd7, 32'd6);           wait_idle();
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    start_op(2'b01, 32'h8000_0000, 32'd2);   wait_idle();
    start_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    start_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0); wait_idle();

    // flush at N+10 of a mul: no done, result keeps its prior value
    start_op(2'b00, 32'd1000, 32'hFFFF_0001);
    repeat (9) tick();
    flush_now();
    tick();

    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    repeat (2) tick();

    // reset at N+5 clears everything, including the held result
    start_op(2'b10, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    last_res = '0;
    repeat (2) tick();

    start_op(2'b00, 32'd11, 32'd13);
    back_to_back(2'b01, 32'hFFFF_FFF0, 32'd5);
    wait_idle();

    start_op(2'b00, 32'hFFFF_FFFF, 32'd0);   wait_idle();

    for (int i = 0; i < 40; i++) begin
      logic [1:0] o;
      o = 2'($urandom_range(0, 3));
      start_op(o, pick_val(), pick_val());
      case ($urandom_range(0, 4))
        0: begin
          repeat ($urandom_range(0, 20)) tick();
          flush_now();
          tick();
        end
        1: begin
          back_to_back(2'($urandom_range(0, 3)), pick_val(), pick_val());
          wait_idle();
        end
        default: wait_idle();
      endcase
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
